pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage MIPS pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Detects load-use and jr-operand hazards, handles taken jr/branch redirects and data-memory wait states.
//  Drives write-enables, flushes and the freeze/bubble controls of every stage register.
//  Keeps a saturating stall counter for performance debug.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive MEM_Ready-low cycles before MemTimeout asserts
//  CNT_W        16  width of StallCycles counter
// PORTS
//  Clk          in   1      clock, rising edge
//  Reset        in   1      asynchronous, active-high
//  ID_Rs        in   5      rs field of instruction in ID
//  ID_Rt        in   5      rt field of instruction in ID
//  ID_UsesRt    in   1      ID instruction reads rt
//  ID_jr        in   1      ID instruction is jr (reads rs in ID)
//  ID_Redirect  in   1      taken branch/jump/jr resolved in ID this cycle
//  EX_MemRead   in   1      ID/EX holds a load
//  EX_RegWrite  in   1      ID/EX writes a register
//  EX_RegDst    in   5      ID/EX destination register
//  MEM_MemRead  in   1      EX/MEM holds a load
//  MEM_RegDst   in   5      EX/MEM destination register
//  MEM_Req      in   1      EX/MEM issues a data-memory access this cycle
//  MEM_Ready    in   1      data memory completes access this cycle
//  PC_Write     out  1      PC update enable
//  IF_ID_Write  out  1      IF/ID load enable
//  IF_ID_Flush  out  1      IF/ID cleared to NOP on next edge
//  ID_EX_Flush  out  1      ID/EX control cleared (bubble) on next edge
//  Pipe_Freeze  out  1      ID/EX and EX/MEM hold contents
//  MEM_WB_Bubble out 1      MEM/WB loads zero control (RegWrite=0, jr=0)
//  MemTimeout   out  1      sticky; memory wait exceeded MEM_TIMEOUT
//  StallCycles  out  CNT_W  saturating count of cycles with PC_Write=0 (after reset)
// BEHAVIOUR
//  - Reset asserted: state=RUN, PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1,
//    Pipe_Freeze=0, MEM_WB_Bubble=1, MemTimeout=0, StallCycles=0. Outputs valid same cycle.
//  - States: RUN, MEM_WAIT. Hazard outputs are combinational from state+inputs (zero latency).
//  - Reg 0 never a hazard source (RegDst==0 ignored).
//  - Priority (highest first) in RUN:
//    1 MEM_Req & !MEM_Ready: go MEM_WAIT; PC_Write=0, IF_ID_Write=0, Pipe_Freeze=1, MEM_WB_Bubble=1.
//    2 load-use: EX_MemRead & EX_RegDst!=0 & (EX_RegDst==ID_Rs | (ID_UsesRt & EX_RegDst==ID_Rt)):
//      PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. One cycle per occurrence.
//    3 jr-operand: ID_jr & ((EX_RegWrite & EX_RegDst==ID_Rs) | (MEM_MemRead & MEM_RegDst==ID_Rs)):
//      same as 2; ID_Redirect ignored while stalled.
//    4 ID_Redirect: IF_ID_Flush=1, PC_Write=1.
//    5 otherwise: PC_Write=1, IF_ID_Write=1, all flush/freeze/bubble=0.
//  - MEM_WAIT: hold freeze outputs; wait counter increments each cycle. On MEM_Ready=1: release
//    freeze that cycle (normal RUN evaluation of 2-5), return RUN, clear wait counter.
//    Counter reaching MEM_TIMEOUT sets MemTimeout (sticky until Reset); FSM stays in MEM_WAIT.
//  - MEM_Req & MEM_Ready same cycle in RUN: no wait state.
//  - StallCycles: +1 per edge where PC_Write=0 and Reset=0; saturates at all-ones, no wrap.
//  - Reset mid-MEM_WAIT: immediate return to RUN, counters cleared, no residual freeze.
// STRUCTURE
//  - Shared package: state encodings (RUN=1'b0, MEM_WAIT=1'b1), opcode/funct constants for jr.
//  - One sub-module natural: hazard_compare (pure comparator for load-use/jr-operand terms).
//  - FSM + counters in top; outputs combinational, counters/state registered.
// TESTING
//  1 Reset pulse mid-run -> PC_Write=0, ID_EX_Flush=1, StallCycles=0 during Reset; RUN after.
//  2 EX_MemRead=1,EX_RegDst=5,ID_Rs=5 -> 1 cycle PC_Write=0, ID_EX_Flush=1; same with RegDst=0 -> no stall.
//  3 ID_jr=1,ID_Rs=8,MEM_MemRead=1,MEM_RegDst=8 -> stall; ID_Redirect ignored that cycle.
//  4 MEM_Req=1,MEM_Ready=0 for 3 cycles -> Pipe_Freeze=1 for 3 cycles, released on Ready; StallCycles+=3.
//  5 MEM_Ready held 0 for MEM_TIMEOUT cycles -> MemTimeout=1, stays set until Reset.
//  6 Load-use + ID_Redirect same cycle -> stall wins, IF_ID_Flush=0; redirect acted on next cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  // MIPS encoding of jr (SPECIAL opcode, funct 0x08), kept here so the decode
  // side and the hazard side agree on what "jr" means.
  localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
  localparam logic [5:0] FUNCT_JR       = 6'h08;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  // One bundle for every stage-register control the block drives.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_freeze;
    logic mem_wb_bubble;
  } ctrl_t;

  // Control patterns for each pipeline situation.
  localparam ctrl_t CTRL_RESET    = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                      id_ex_flush: 1'b1, pipe_freeze: 1'b0, mem_wb_bubble: 1'b1};
  localparam ctrl_t CTRL_FREEZE   = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      id_ex_flush: 1'b0, pipe_freeze: 1'b1, mem_wb_bubble: 1'b1};
  localparam ctrl_t CTRL_STALL    = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      id_ex_flush: 1'b1, pipe_freeze: 1'b0, mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                      id_ex_flush: 1'b0, pipe_freeze: 1'b0, mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_RUN      = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                      id_ex_flush: 1'b0, pipe_freeze: 1'b0, mem_wb_bubble: 1'b0};

  // True when a producer destination feeds a consumer source; r0 never counts.
  function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] dst,
                                   input logic [REG_ADDR_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_compare.sv
// Pure comparator: flags load-use and jr-operand hazards for the ID instruction.
module pipeline_hazard_ctrl_hazard_compare
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_jr,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_reg_dst,
  input  logic                  mem_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_reg_dst,
  output logic                  load_use,
  output logic                  jr_operand
);

  logic [REG_ADDR_W-1:0] ex_rs_eq;
  logic [REG_ADDR_W-1:0] ex_rt_eq;
  logic [REG_ADDR_W-1:0] mem_rs_eq;

  // Per-bit equality between producer destinations and ID source fields.
  generate
    for (genvar gi = 0; gi < REG_ADDR_W; gi++) begin : g_bit_eq
      assign ex_rs_eq[gi]  = ~(ex_reg_dst[gi]  ^ id_rs[gi]);
      assign ex_rt_eq[gi]  = ~(ex_reg_dst[gi]  ^ id_rt[gi]);
      assign mem_rs_eq[gi] = ~(mem_reg_dst[gi] ^ id_rs[gi]);
    end
  endgenerate

  logic ex_dst_nz;
  logic mem_dst_nz;
  logic ex_hits_rs;
  logic ex_hits_rt;
  logic mem_hits_rs;

  assign ex_dst_nz   = |ex_reg_dst;
  assign mem_dst_nz  = |mem_reg_dst;
  assign ex_hits_rs  = ex_dst_nz  & (&ex_rs_eq);
  assign ex_hits_rt  = ex_dst_nz  & (&ex_rt_eq);
  assign mem_hits_rs = mem_dst_nz & (&mem_rs_eq);

  // A load in EX cannot forward to ID's consumer in time; jr reads rs in ID so
  // any in-flight writer of rs in EX, or a load in MEM, must drain first.
  always_comb begin
    load_use   = ex_mem_read & (ex_hits_rs | (id_uses_rt & ex_hits_rt));
    jr_operand = id_jr & ((ex_reg_write & ex_hits_rs) | (mem_mem_read & mem_hits_rs));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencing: hazards, redirects, data-memory wait states,
// memory timeout flag and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRt,
  input  logic                  ID_jr,
  input  logic                  ID_Redirect,
  input  logic                  EX_MemRead,
  input  logic                  EX_RegWrite,
  input  logic [REG_ADDR_W-1:0] EX_RegDst,
  input  logic                  MEM_MemRead,
  input  logic [REG_ADDR_W-1:0] MEM_RegDst,
  input  logic                  MEM_Req,
  input  logic                  MEM_Ready,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Flush,
  output logic                  Pipe_Freeze,
  output logic                  MEM_WB_Bubble,
  output logic                  MemTimeout,
  output logic [CNT_W-1:0]      StallCycles
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  state_t            state_reg;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              timeout_reg;
  logic              timeout_next;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  stall_cnt_next;
  ctrl_t             ctrl;
  logic              mem_stall;
  logic              load_use;
  logic              jr_operand;

  pipeline_hazard_ctrl_hazard_compare u_hazard_compare (
    .id_rs        (ID_Rs),
    .id_rt        (ID_Rt),
    .id_uses_rt   (ID_UsesRt),
    .id_jr        (ID_jr),
    .ex_mem_read  (EX_MemRead),
    .ex_reg_write (EX_RegWrite),
    .ex_reg_dst   (EX_RegDst),
    .mem_mem_read (MEM_MemRead),
    .mem_reg_dst  (MEM_RegDst),
    .load_use     (load_use),
    .jr_operand   (jr_operand)
  );

  // Next state and stage controls; memory wait outranks every ID-stage hazard,
  // and reset overrides all of it so outputs are safe while Reset is high.
  always_comb begin
    ctrl          = CTRL_RUN;
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    // Entering from RUN the counter is zero, so this yields 1 on the first low cycle.
    mem_stall     = !MEM_Ready && ((state_reg == ST_MEM_WAIT) || MEM_Req);

    if (mem_stall) begin
      ctrl       = CTRL_FREEZE;
      state_next = ST_MEM_WAIT;
      if (wait_cnt_reg != WAIT_LIMIT) begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
      end
    end else begin
      state_next    = ST_RUN;
      wait_cnt_next = '0;
      if (load_use || jr_operand) begin
        ctrl = CTRL_STALL;
      end else if (ID_Redirect) begin
        ctrl = CTRL_REDIRECT;
      end
    end

    if (Reset) begin
      ctrl = CTRL_RESET;
    end
  end

  // Sticky timeout and saturating stall counter updates.
  always_comb begin
    timeout_next   = timeout_reg || (wait_cnt_next == WAIT_LIMIT);
    stall_cnt_next = stall_cnt_reg;
    if (!ctrl.pc_write && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_next = stall_cnt_reg + 1'b1;
    end
  end

  // State, wait counter, timeout flag and stall counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= ST_RUN;
      wait_cnt_reg  <= '0;
      timeout_reg   <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      timeout_reg   <= timeout_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign PC_Write      = ctrl.pc_write;
  assign IF_ID_Write   = ctrl.if_id_write;
  assign IF_ID_Flush   = ctrl.if_id_flush;
  assign ID_EX_Flush   = ctrl.id_ex_flush;
  assign Pipe_Freeze   = ctrl.pipe_freeze;
  assign MEM_WB_Bubble = ctrl.mem_wb_bubble;
  assign MemTimeout    = timeout_reg;
  assign StallCycles   = stall_cnt_reg;

endmodule
